// File: rtl/cos_sine_pkg.sv
// Shared constants, quadrant type and table builders for the sine/cosine generator.
// The tables are computed at elaboration with fixed-point Taylor series, so no real math reaches synthesis.
package cos_sine_pkg;

  localparam int PHASE_W = 10;
  localparam int AMP_W   = 8;
  localparam int AMP_MAX = 127;
  localparam int QUARTER = 256;
  localparam int QTR_W   = PHASE_W - 2;

  typedef enum logic [1:0] {
    QUAD_0 = 2'd0,
    QUAD_1 = 2'd1,
    QUAD_2 = 2'd2,
    QUAD_3 = 2'd3
  } quad_e;

  typedef logic [QUARTER-1:0][AMP_W-2:0]   qtbl_t;
  typedef logic [4*QUARTER-1:0][AMP_W-1:0] ftbl_t;

  // pi in Q30
  localparam longint PI_Q30 = 64'sd3373259426;

  // round(127*sin(2*pi*k/1024)), half away from zero; k < 256 keeps the angle below pi/2
  function automatic logic [AMP_W-2:0] quarter_mag(input logic [QTR_W-1:0] k);
    longint theta;
    longint theta2;
    longint term;
    longint acc;
    theta  = (PI_Q30 * longint'(k)) >>> 9;
    theta2 = (theta * theta) >>> 30;
    term   = theta;
    acc    = theta;
    for (int n = 1; n <= 8; n++) begin
      term = -((term * theta2) >>> 30) / longint'((2 * n) * (2 * n + 1));
      acc  = acc + term;
    end
    return (AMP_W-1)'((longint'(AMP_MAX) * acc + (longint'(1) <<< 29)) >>> 30);
  endfunction

  function automatic logic is_mirrored(input quad_e q);
    return (q == QUAD_1) || (q == QUAD_3);
  endfunction

  // Odd quadrants read the table backwards; i==0 wraps to 0 and is covered by the peak flag.
  function automatic logic [QTR_W-1:0] mirror_addr(input quad_e q, input logic [QTR_W-1:0] i);
    return is_mirrored(q) ? QTR_W'(QUARTER - int'(i)) : i;
  endfunction

  function automatic qtbl_t build_quarter_table();
    qtbl_t t;
    for (int k = 0; k < QUARTER; k++) begin
      t[k[QTR_W-1:0]] = quarter_mag(k[QTR_W-1:0]);
    end
    return t;
  endfunction

  function automatic ftbl_t build_full_table();
    ftbl_t            t;
    logic [AMP_W-2:0] m;
    for (int q = 0; q < 4; q++) begin
      for (int i = 0; i < QUARTER; i++) begin
        if (q == 1 || q == 3)
          m = (i == 0) ? (AMP_W-1)'(AMP_MAX) : quarter_mag(QTR_W'(QUARTER - i));
        else
          m = quarter_mag(i[QTR_W-1:0]);
        t[{q[1:0], i[QTR_W-1:0]}] = (q >= 2) ? AMP_W'(-{1'b0, m}) : {1'b0, m};
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/cos_sine_if.sv
// Phase-in / sine-cosine-out bundle; the phase source is the master, the generator the slave.
interface cos_sine_if;
  import cos_sine_pkg::*;

  logic        [PHASE_W-1:0] x;
  logic signed [AMP_W-1:0]   y_sine;
  logic signed [AMP_W-1:0]   y_cos;

  modport master (output x, input  y_sine, input  y_cos);
  modport slave  (input  x, output y_sine, output y_cos);

endinterface

// File: rtl/cos_sine_core_rom.sv
// quarter_sine_rom: 256x7 quarter-wave magnitude ROM, two independent registered read ports.
// Read registers clear on reset because they form the first pipeline stage of the generator.
module quarter_sine_rom
  import cos_sine_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [QTR_W-1:0] addr_sin_i,
  input  logic [QTR_W-1:0] addr_cos_i,
  output logic [AMP_W-2:0] mag_sin_o,
  output logic [AMP_W-2:0] mag_cos_o
);

  localparam qtbl_t QTBL = build_quarter_table();

  logic [AMP_W-2:0] mag_sin_q;
  logic [AMP_W-2:0] mag_cos_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_sin_q <= '0;
      mag_cos_q <= '0;
    end else begin
      mag_sin_q <= QTBL[addr_sin_i];
      mag_cos_q <= QTBL[addr_cos_i];
    end
  end

  assign mag_sin_o = mag_sin_q;
  assign mag_cos_o = mag_cos_q;

endmodule

// File: rtl/cos_sine_core.sv
// cos_sine_core: phase word to signed sine/cosine samples, two-cycle latency, one sample per clock.
// Define COS_SINE_FULL_ROM_EN to replace quarter-wave mirroring with full 1024-entry signed tables.
module cos_sine_core
  import cos_sine_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  cos_sine_if.slave bus
);

  logic        [PHASE_W-1:0] x_cos;
  logic signed [AMP_W-1:0]   y_sine_d;
  logic signed [AMP_W-1:0]   y_cos_d;
  logic signed [AMP_W-1:0]   y_sine_q;
  logic signed [AMP_W-1:0]   y_cos_q;

  // cosine is sine a quarter turn ahead; the carry out of bit 9 is dropped
  assign x_cos = bus.x + PHASE_W'(QUARTER);

`ifdef COS_SINE_FULL_ROM_EN

  localparam ftbl_t FULL_TBL = build_full_table();

  logic signed [AMP_W-1:0] sin_s1_q;
  logic signed [AMP_W-1:0] cos_s1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sin_s1_q <= '0;
      cos_s1_q <= '0;
    end else begin
      sin_s1_q <= FULL_TBL[bus.x];
      cos_s1_q <= FULL_TBL[x_cos];
    end
  end

  assign y_sine_d = sin_s1_q;
  assign y_cos_d  = cos_s1_q;

`else

  quad_e            quad_sin;
  quad_e            quad_cos;
  logic [QTR_W-1:0] addr_sin;
  logic [QTR_W-1:0] addr_cos;
  logic             peak_sin_d, peak_cos_d, neg_sin_d, neg_cos_d;
  logic             peak_sin_q, peak_cos_q, neg_sin_q, neg_cos_q;
  logic [AMP_W-2:0] mag_sin_rom, mag_cos_rom;
  logic [AMP_W-2:0] mag_sin, mag_cos;

  always_comb begin
    quad_sin   = quad_e'(bus.x[PHASE_W-1 -: 2]);
    quad_cos   = quad_e'(x_cos[PHASE_W-1 -: 2]);
    addr_sin   = mirror_addr(quad_sin, bus.x[QTR_W-1:0]);
    addr_cos   = mirror_addr(quad_cos, x_cos[QTR_W-1:0]);
    peak_sin_d = is_mirrored(quad_sin) && (bus.x[QTR_W-1:0] == '0);
    peak_cos_d = is_mirrored(quad_cos) && (x_cos[QTR_W-1:0] == '0);
    neg_sin_d  = quad_sin inside {QUAD_2, QUAD_3};
    neg_cos_d  = quad_cos inside {QUAD_2, QUAD_3};
  end

  quarter_sine_rom u_rom (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr_sin_i (addr_sin),
    .addr_cos_i (addr_cos),
    .mag_sin_o  (mag_sin_rom),
    .mag_cos_o  (mag_cos_rom)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_sin_q <= 1'b0;
      peak_cos_q <= 1'b0;
      neg_sin_q  <= 1'b0;
      neg_cos_q  <= 1'b0;
    end else begin
      peak_sin_q <= peak_sin_d;
      peak_cos_q <= peak_cos_d;
      neg_sin_q  <= neg_sin_d;
      neg_cos_q  <= neg_cos_d;
    end
  end

  always_comb begin
    mag_sin  = peak_sin_q ? (AMP_W-1)'(AMP_MAX) : mag_sin_rom;
    mag_cos  = peak_cos_q ? (AMP_W-1)'(AMP_MAX) : mag_cos_rom;
    y_sine_d = neg_sin_q ? AMP_W'(-{1'b0, mag_sin}) : {1'b0, mag_sin};
    y_cos_d  = neg_cos_q ? AMP_W'(-{1'b0, mag_cos}) : {1'b0, mag_cos};
  end

`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_sine_q <= '0;
      y_cos_q  <= '0;
    end else begin
      y_sine_q <= y_sine_d;
      y_cos_q  <= y_cos_d;
    end
  end

  assign bus.y_sine = y_sine_q;
  assign bus.y_cos  = y_cos_q;

endmodule

// File: tb/tb_cos_sine_core.sv
// Directed and ramp checks for cos_sine_core: cardinal/octant points, latency, wrap, symmetry, async reset.
module tb_cos_sine_core;

  localparam real PI = 3.14159265358979323846;

  logic clk;
  logic rst_n;

  cos_sine_if bus ();

  cos_sine_core dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // expected-output pipeline: p0 = value driven last negedge, p1 = the one due now
  logic [7:0] p0_s, p0_c, p1_s, p1_c;
  logic [9:0] p0_x, p1_x;
  bit         rec_en;
  logic signed [7:0] rec_s [1024];
  logic signed [7:0] rec_c [1024];

  function automatic logic [7:0] gold(input int xx, input bit cosine);
    real a;
    real r;
    int  m;
    a = 2.0 * PI * real'(xx) / 1024.0;
    r = 127.0 * (cosine ? $cos(a) : $sin(a));
    m = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
    return 8'(m);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic tick(input logic [9:0] xv, input logic [7:0] es, input logic [7:0] ec);
    @(negedge clk);
    chk($sformatf("sin_x%0d", p1_x), bus.y_sine, p1_s);
    chk($sformatf("cos_x%0d", p1_x), bus.y_cos, p1_c);
    n_assert++;
    assert (bus.y_sine !== 8'h80 && bus.y_cos !== 8'h80) else begin
      n_fail++;
      $error("FAIL no_minus128 observed sin=%0d cos=%0d required not -128",
             $signed(bus.y_sine), $signed(bus.y_cos));
    end
    if (rec_en) begin
      rec_s[p1_x] = bus.y_sine;
      rec_c[p1_x] = bus.y_cos;
    end
    p1_s = p0_s; p1_c = p0_c; p1_x = p0_x;
    p0_s = es;   p0_c = ec;   p0_x = xv;
    bus.x = xv;
  endtask

  initial begin
    rec_en = 1'b0;
    bus.x  = '0;
    rst_n  = 1'b1;
    p0_s = '0; p0_c = '0; p1_s = '0; p1_c = '0; p0_x = '0; p1_x = '0;
    #1 rst_n = 1'b0;
    #11;
    chk("reset_sin", bus.y_sine, 8'd0);
    chk("reset_cos", bus.y_cos, 8'd0);

    // release between edges; held x=0 is the first sample
    @(negedge clk);
    rst_n = 1'b1;
    p1_s = 8'd0; p1_c = 8'd0; p1_x = 10'd0;
    p0_s = 8'd0; p0_c = 8'd127; p0_x = 10'd0;

    tick(10'd0,    8'sd0,    8'sd127);
    tick(10'd256,  8'sd127,  8'sd0);
    tick(10'd512,  8'sd0,   -8'sd127);
    tick(10'd768, -8'sd127,  8'sd0);
    tick(10'd128,  8'sd90,   8'sd90);
    tick(10'd384,  8'sd90,  -8'sd90);
    tick(10'd640, -8'sd90,  -8'sd90);
    tick(10'd896, -8'sd90,   8'sd90);
    tick(10'd1023, -8'sd1,   8'sd127);
    tick(10'd0,    8'sd0,    8'sd127);
    tick(10'd1,    8'sd1,    8'sd127);
    tick(10'd511,  8'sd1,   -8'sd127);

    // continuous ramp across 1023->0, with an asynchronous reset in the middle
    for (int pass = 0; pass < 8; pass++) begin
      for (int xx = 0; xx < 1024; xx++) begin
        rec_en = (pass == 1) || (pass == 2);
        if (pass == 5 && xx == 500) begin
          @(posedge clk);
          #2 rst_n = 1'b0;
          #1;
          chk("async_rst_sin", bus.y_sine, 8'd0);
          chk("async_rst_cos", bus.y_cos, 8'd0);
          @(negedge clk);
          chk("held_rst_sin", bus.y_sine, 8'd0);
          chk("held_rst_cos", bus.y_cos, 8'd0);
          rst_n = 1'b1;
          p1_s = 8'd0; p1_c = 8'd0; p1_x = bus.x;
          p0_s = gold(int'(bus.x), 1'b0);
          p0_c = gold(int'(bus.x), 1'b1);
          p0_x = bus.x;
        end
        tick(10'(xx), gold(xx, 1'b0), gold(xx, 1'b1));
      end
    end
    tick(10'd0, gold(0, 1'b0), gold(0, 1'b1));
    tick(10'd0, gold(0, 1'b0), gold(0, 1'b1));

    for (int xx = 0; xx < 1024; xx++) begin
      chk($sformatf("sym_half_x%0d", xx), rec_s[xx], 8'(-rec_s[(xx + 512) % 1024]));
      chk($sformatf("sym_quarter_x%0d", xx), rec_c[xx], rec_s[(xx + 256) % 1024]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
